// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for the multi-cycle MIPS core. Decodes the instruction opcode and
// funct fields together with the ALU zero flag, and drives every datapath
// select and enable. It also raises the memory write strobe, waits on the
// memory ready handshake, counts retired instructions and flags unsupported
// opcodes or funct codes.
//
// Parameters
//   USE_MEM_READY  1: FETCH/MEMRD/MEMWR hold until MemReady=1
//                  0: MemReady is ignored and treated as 1
//   CNT_W          width of InstrCount
//
// Ports
//   clk                    in   rising-edge clock
//   reset                  in   asynchronous, active-low (0 = in reset)
//   opField                in   instr[31:26]
//   functField             in   instr[5:0]
//   ALUResultZero          in   ALU zero flag (combinational, same cycle)
//   MemReady               in   memory finished the current access this cycle
//   WriteData_Sel          out  00 ALUOut, 01 mem data, 10 PC
//   RegDst_Sel             out  00 rt, 01 rd, 10 r31
//   InstructionOrData_Sel  out  0 PC, 1 ALUOut
//   ALUsourceA_Sel         out  0 PC, 1 rs
//   ALUsourceB_Sel         out  00 rt, 01 const 4, 10 imm, 11 imm<<2
//   PCsource_Sel           out  00 ALUResult, 01 ALUOut, 10 jump target
//   PCWrite_Enable         out  PC load, including the branch-taken term
//   RegWrite_Enable        out  register file write
//   InstrLatch             out  instruction latch enable
//   ALUControl             out  010 add, 110 sub, 000 and, 001 or, 111 slt
//   MemWrite               out  memory write strobe
//   IllegalOp              out  one-cycle pulse on unsupported opcode/funct
//   InstrCount             out  retired instruction count (wraps silently)
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter bit USE_MEM_READY = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opField,
    input  logic [5:0]       functField,
    input  logic             ALUResultZero,
    input  logic             MemReady,
    output logic [1:0]       WriteData_Sel,
    output logic [1:0]       RegDst_Sel,
    output logic             InstructionOrData_Sel,
    output logic             ALUsourceA_Sel,
    output logic [1:0]       ALUsourceB_Sel,
    output logic [1:0]       PCsource_Sel,
    output logic             PCWrite_Enable,
    output logic             RegWrite_Enable,
    output logic             InstrLatch,
    output logic [2:0]       ALUControl,
    output logic             MemWrite,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] instr_cnt;
    logic             illegal_q;

    logic             mem_rdy;
    logic             illegal_set;
    logic             retire;

    // Raw Moore decode, gated by reset before reaching the ports
    logic [1:0]       wd_sel;
    logic [1:0]       rd_sel;
    logic             iord_sel;
    logic             srca_sel;
    logic [1:0]       srcb_sel;
    logic [1:0]       pcsrc_sel;
    logic             pc_write;
    logic             branch;
    logic             reg_write;
    logic             instr_latch;
    logic [2:0]       alu_ctl;
    logic             mem_write;

    assign mem_rdy = USE_MEM_READY ? MemReady : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            instr_cnt <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= next_state;
            illegal_q <= illegal_set;
            if (retire) begin
                instr_cnt <= instr_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        next_state  = state;
        illegal_set = 1'b0;
        retire      = 1'b0;
        wd_sel      = 2'b00;
        rd_sel      = 2'b00;
        iord_sel    = 1'b0;
        srca_sel    = 1'b0;
        srcb_sel    = 2'b00;
        pcsrc_sel   = 2'b00;
        pc_write    = 1'b0;
        branch      = 1'b0;
        reg_write   = 1'b0;
        instr_latch = 1'b0;
        alu_ctl     = 3'b000;
        mem_write   = 1'b0;

        case (state)
            S_FETCH: begin
                instr_latch = 1'b1;
                srcb_sel    = 2'b01;
                alu_ctl     = ALU_ADD;
                // PC+4 is only committed once the fetch has actually completed
                pc_write    = mem_rdy;
                if (mem_rdy) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                srcb_sel = 2'b11;
                alu_ctl  = ALU_ADD;
                case (opField)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTEX;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    OP_JAL:       next_state = S_JAL;
                    default: begin
                        next_state  = S_FETCH;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                srca_sel   = 1'b1;
                srcb_sel   = 2'b10;
                alu_ctl    = ALU_ADD;
                next_state = (opField == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord_sel = 1'b1;
                if (mem_rdy) begin
                    next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                wd_sel     = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                // Strobe stays up across the whole wait so memory sees a stable request
                iord_sel  = 1'b1;
                mem_write = 1'b1;
                if (mem_rdy) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_RTEX: begin
                srca_sel   = 1'b1;
                next_state = S_RTWB;
                case (functField)
                    FN_ADD:  alu_ctl = ALU_ADD;
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    default: begin
                        // Skip RTWB so nothing lands in the register file
                        next_state  = S_FETCH;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            S_RTWB: begin
                rd_sel     = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BEQ: begin
                srca_sel   = 1'b1;
                alu_ctl    = ALU_SUB;
                pcsrc_sel  = 2'b01;
                branch     = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                srca_sel   = 1'b1;
                srcb_sel   = 2'b10;
                alu_ctl    = ALU_ADD;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_sel  = 2'b10;
                pc_write   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 here, so it is the link value for r31
                pcsrc_sel  = 2'b10;
                pc_write   = 1'b1;
                rd_sel     = 2'b10;
                wd_sel     = 2'b10;
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Holding reset low forces every select and strobe to zero straight away,
    // so an abandoned instruction cannot leave a write asserted.
    assign WriteData_Sel         = reset ? wd_sel    : 2'b00;
    assign RegDst_Sel            = reset ? rd_sel    : 2'b00;
    assign InstructionOrData_Sel = reset & iord_sel;
    assign ALUsourceA_Sel        = reset & srca_sel;
    assign ALUsourceB_Sel        = reset ? srcb_sel  : 2'b00;
    assign PCsource_Sel          = reset ? pcsrc_sel : 2'b00;
    assign PCWrite_Enable        = reset & (pc_write | (branch & ALUResultZero));
    assign RegWrite_Enable       = reset & reg_write;
    assign InstrLatch            = reset & instr_latch;
    assign ALUControl            = reset ? alu_ctl   : 3'b000;
    assign MemWrite              = reset & mem_write;
    assign IllegalOp             = reset & illegal_q;
    assign InstrCount            = instr_cnt;

endmodule
